main_ctl_hs: RTL
================

# main_ctl_hs

Parametrised multicycle main controller with a memory handshake. Sequences each RV32I instruction through FETCH, DECODE, EXECUTE, an optional MEMORY phase and WRITEBACK. Drives the enables for the fetch unit, instruction decoder, ALU, GP register file and data memory. It adds variable-latency memory waits with a timeout, load/store and branch/jump paths, a sticky fault state, and cycle/retired-instruction counters.

## Interface
Parameters:
- MAX_WAIT, 15: maximum wait cycles allowed on one memory access before fault; must be ≥ 1.
- WAIT_W, 4: width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT.
- CNT_W, 32: width of cycle_cnt and instret_cnt.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ce  in  1  global clock enable; 0 freezes the controller.
- opcode  in  7  instr[6:0] of the latched instruction; stable from DECODE until retire.
- branch_taken  in  1  branch comparison result from the ALU; valid in EXECUTE.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request, asserted in FETCH and MEMORY.
- mem_we  out  1  write strobe; asserted in MEMORY for STORE only.
- fetch_en, instrdec_ce, alu_ce, gp_regfile_ce, gp_regfile_we, memory_ce  out  1 each  unit enables.
- pc_inc, pc_load  out  1 each  PC advance by 4, or load of the target from the ALU.
- fault  out  1  sticky error flag.
- state  out  3  current state encoding.
- cycle_cnt, instret_cnt  out  CNT_W each  free-running counters.

## Operation
- State encodings: RESET=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, FAULT=6.
- Legal opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011.
- RESET → FETCH.
- FETCH:
  - If mem_ready → DECODE.
  - Else if wait_cnt == MAX_WAIT → FAULT.
  - Else stay in FETCH and increment wait_cnt.
- DECODE: illegal opcode → FAULT; otherwise → EXECUTE.
- EXECUTE: LOAD or STORE → MEMORY; BRANCH → FETCH; all others → WRITEBACK.
- MEMORY:
  - On mem_ready: LOAD → WRITEBACK, STORE → FETCH.
  - Timeout rule is the same as FETCH.
- WRITEBACK → FETCH.
- FAULT: absorbing; only reset_n exits it. fault=1 in this state.
- wait_cnt clears on every entry to FETCH or MEMORY.
- Output decode (Moore on state, qualified by opcode):
  - fetch_en = FETCH.
  - instrdec_ce = DECODE.
  - alu_ce = EXECUTE and opcode ≠ LUI.
  - gp_regfile_ce = EXECUTE or WRITEBACK.
  - memory_ce = mem_req = FETCH or MEMORY.
  - mem_we = MEMORY and STORE.
  - gp_regfile_we = WRITEBACK.
- Retire cycle: the last cycle of an instruction, i.e.:
  - WRITEBACK;
  - EXECUTE for BRANCH;
  - MEMORY with mem_ready for STORE.
- In the retire cycle only:
  - pc_load = JAL, or JALR, or (BRANCH and branch_taken);
  - pc_inc = not pc_load.
  - pc_inc and pc_load are never both 1.
- ce=0:
  - state, wait_cnt and both counters hold;
  - every strobe output is forced 0 (mem_req and mem_we included);
  - state and fault still reflect the held state.
- cycle_cnt increments on every ce=1 cycle, including in FAULT.
- instret_cnt increments on each retire cycle with ce=1.
- Both counters wrap modulo 2^CNT_W.

## Timing
- Reset (async assert, sync-to-clk release):
  - state=RESET, wait_cnt=0, cycle_cnt=0, instret_cnt=0, fault=0.
  - All strobes are 0 during reset.
- First FETCH occurs in the second rising edge after reset_n deasserts with ce=1.
- Zero-wait latency per instruction in cycles: OP/OP_IMM/LUI/AUIPC/JAL/JALR 4, LOAD 5, STORE 4, BRANCH 3.
- Each wait cycle adds 1.
- mem_ready in the same cycle as mem_req completes the access (zero wait).
- mem_req is held until mem_ready or timeout.
- Timeout: an access with no mem_ready asserts mem_req for exactly MAX_WAIT+1 ce-cycles, then enters FAULT.
- mem_ready outside FETCH/MEMORY is ignored.
- reset_n low in any state, mid-wait included, forces RESET immediately; the outstanding request is dropped.

## Test plan
- Reset, then ce=1, mem_ready=1, opcode=OP, repeat 3 instructions:
  - state sequence 0,1,2,3,5,1,…;
  - gp_regfile_we and pc_inc high once per 4 cycles;
  - instret_cnt=3 after 13 cycles.
- LOAD with mem_ready low for 3 cycles in MEMORY:
  - MEMORY lasts 4 cycles, mem_we=0;
  - then WRITEBACK;
  - total 8 cycles.
- STORE with zero wait:
  - mem_we=1 for one cycle in MEMORY;
  - pc_inc in that cycle;
  - next state FETCH; no WRITEBACK.
- BRANCH with branch_taken=1, then with branch_taken=0:
  - 3-cycle instructions;
  - pc_load=1, pc_inc=0 on the first; pc_inc=1 on the second.
- mem_ready stuck 0 in FETCH with MAX_WAIT=15:
  - mem_req high exactly 16 cycles;
  - then state=6, fault=1 until reset_n pulse.
  - Also: illegal opcode 1111111 in DECODE goes to FAULT.
- ce dropped for 5 cycles mid-EXECUTE, and reset_n asserted mid-FETCH wait:
  - during ce=0, state and counters hold and strobes are 0;
  - on reset_n low, state=0 and counters=0 immediately.

Source files
------------

// File: rtl/main_ctl_hs.sv
// Multicycle RV32I main controller: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
// handles variable-latency memory with a timeout, and keeps cycle/retire counters.
module main_ctl_hs #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             fetch_en,
    output logic             instrdec_ce,
    output logic             alu_ce,
    output logic             gp_regfile_ce,
    output logic             gp_regfile_we,
    output logic             memory_ce,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    state_t            cur_state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_next;

    logic is_lui, is_jal, is_jalr, is_branch, is_load, is_store, is_legal;
    logic retire;
    logic timed_out;

    assign is_lui    = (opcode == OPC_LUI);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_legal  = is_lui || is_jal || is_jalr || is_branch || is_load || is_store
                     || (opcode == OPC_AUIPC) || (opcode == OPC_OP_IMM) || (opcode == OPC_OP);
    assign timed_out = (wait_cnt == WAIT_W'(MAX_WAIT));

    // wait_cnt only survives while a memory access stays pending; any state change clears it
    always_comb begin
        next_state    = cur_state;
        wait_cnt_next = '0;
        case (cur_state)
            ST_RESET: next_state = ST_FETCH;
            ST_FETCH, ST_MEMORY: begin
                if (mem_ready) begin
                    if (cur_state == ST_FETCH) next_state = ST_DECODE;
                    else if (is_load)          next_state = ST_WRITEBACK;
                    else                       next_state = ST_FETCH;
                end else if (timed_out) begin
                    next_state = ST_FAULT;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end
            ST_DECODE: next_state = is_legal ? ST_EXECUTE : ST_FAULT;
            ST_EXECUTE: begin
                if (is_load || is_store) next_state = ST_MEMORY;
                else if (is_branch)      next_state = ST_FETCH;
                else                     next_state = ST_WRITEBACK;
            end
            ST_WRITEBACK: next_state = ST_FETCH;
            ST_FAULT:     next_state = ST_FAULT;
            default:      next_state = ST_FAULT;
        endcase
    end

    // Every strobe is gated by ce so a frozen controller drives nothing
    always_comb begin
        fetch_en      = ce && (cur_state == ST_FETCH);
        instrdec_ce   = ce && (cur_state == ST_DECODE);
        alu_ce        = ce && (cur_state == ST_EXECUTE) && !is_lui;
        gp_regfile_ce = ce && ((cur_state == ST_EXECUTE) || (cur_state == ST_WRITEBACK));
        gp_regfile_we = ce && (cur_state == ST_WRITEBACK);
        mem_req       = ce && ((cur_state == ST_FETCH) || (cur_state == ST_MEMORY));
        memory_ce     = mem_req;
        mem_we        = ce && (cur_state == ST_MEMORY) && is_store;
        retire        = ce && ((cur_state == ST_WRITEBACK)
                             || ((cur_state == ST_EXECUTE) && is_branch)
                             || ((cur_state == ST_MEMORY) && mem_ready && is_store));
        pc_load       = retire && (is_jal || is_jalr || (is_branch && branch_taken));
        pc_inc        = retire && !pc_load;
    end

    assign state = cur_state;
    assign fault = (cur_state == ST_FAULT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state   <= ST_RESET;
            wait_cnt    <= '0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else if (ce) begin
            cur_state <= next_state;
            wait_cnt  <= wait_cnt_next;
            cycle_cnt <= cycle_cnt + 1'b1;
            if (retire) instret_cnt <= instret_cnt + 1'b1;
        end
    end

endmodule
